matrix_core_3x3_reg_reader: RTL and testbench

- Read-side responder on the sys register bus for the 3x3 matrix-multiply core's coefficient bank.
- Complements the per-register write-select logic. Accepts a read request, decodes the 20-bit address against the nine coefficient registers plus status and ID words, and returns data with an ack after a configurable pipelined latency.
- Sits between the sys bus interconnect and the coefficient register bank of the matrix core.

---
 rtl/matrix_core_3x3_reg_reader_if.sv | 14 +
 rtl/matrix_core_3x3_reg_reader.sv | 161 ++++++++++++++++
 tb/tb_matrix_core_3x3_reg_reader.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/matrix_core_3x3_reg_reader_if.sv
// Read-side sys register bus bundle for the 3x3 matrix core coefficient bank.
// The master drives address and read strobe; the slave returns data, ack and error.
interface matrix_core_3x3_reg_reader_if;
  logic [19:0] sys_addr;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_ack;
  logic        sys_err;

  modport master (output sys_addr, output sys_ren,
                  input  sys_rdata, input sys_ack, input sys_err);
  modport slave  (input  sys_addr, input sys_ren,
                  output sys_rdata, output sys_ack, output sys_err);
endinterface

// File: rtl/matrix_core_3x3_reg_reader.sv
// Read responder for the 3x3 matrix core coefficient bank.
// Decodes c0..c8, status and ID words; acks READ_LAT cycles after the request.
// Optional macro MM3X3_RD_SNAPSHOT_EN: a c0 read snapshots all nine
// coefficients so that c1..c8 reads give a coherent matrix view.
//
// state | meaning
// IDLE  | no read outstanding, ready to accept
// WAIT  | read accepted, counting out the remaining latency
// ACK   | ack/data/err driven for one cycle; a new read may be accepted
module matrix_core_3x3_reg_reader #(
  parameter logic [19:0] BASE_ADDR = 20'h00000,
  parameter int          READ_LAT  = 2,
  parameter logic [31:0] ID_WORD   = 32'h4D4D3333
) (
  input  logic                                 sys_clk_i,
  input  logic                                 sys_rstn_i,
  matrix_core_3x3_reg_reader_if.slave          sys_bus_io,
  input  logic [287:0]                         coef_i,
  input  logic                                 core_busy_i,
  input  logic                                 core_done_i
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  // WAIT holds READ_LAT-1 cycles; counter loads with one less so it ends at zero.
  localparam logic [1:0] WAIT_INIT = 2'((READ_LAT >= 2) ? (READ_LAT - 2) : 0);

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic [31:0] data_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic        ack_q;
  logic        err_o_q;
  logic [15:0] done_cnt_q;
  logic [7:0]  drop_cnt_q;

  logic [20:0] diff_w;
  logic [19:0] offset_w;
  logic        addr_err_w;
  logic        accept_w;
  logic        pending_w;
  logic        shadow_bit_w;
  logic [31:0] rd_word_w;

  // Extra top bit of the subtraction flags addresses below the base.
  assign diff_w     = {1'b0, sys_bus_io.sys_addr} - {1'b0, BASE_ADDR};
  assign offset_w   = diff_w[19:0];
  assign addr_err_w = diff_w[20] || (offset_w > 20'h00028) || (sys_bus_io.sys_addr[1:0] != 2'b00);
  assign accept_w   = sys_bus_io.sys_ren && ((state_q == S_IDLE) || (state_q == S_ACK));
  // The read being sampled is itself outstanding, so pending is always seen as 1.
  assign pending_w  = (state_q != S_IDLE) || accept_w;

`ifdef MM3X3_RD_SNAPSHOT_EN
  logic [287:0] shadow_q;
  logic         shadow_valid_q;

  assign shadow_bit_w = shadow_valid_q;

  // Snapshot the whole matrix whenever c0 is read.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      shadow_q       <= '0;
      shadow_valid_q <= 1'b0;
    end else if (accept_w && !addr_err_w && (offset_w == 20'h00000)) begin
      shadow_q       <= coef_i;
      shadow_valid_q <= 1'b1;
    end
  end
`else
  assign shadow_bit_w = 1'b0;
`endif

  // Read-data mux; unmapped or misaligned addresses return zero.
  always_comb begin
    rd_word_w = '0;
    if (!addr_err_w) begin
      if (offset_w == 20'h00024) begin
        rd_word_w = {drop_cnt_q, done_cnt_q, 5'b0, shadow_bit_w, core_busy_i, pending_w};
      end else if (offset_w == 20'h00028) begin
        rd_word_w = ID_WORD;
      end else begin
        for (int k = 0; k < 9; k++) begin
          if (offset_w[5:2] == 4'(k)) begin
`ifdef MM3X3_RD_SNAPSHOT_EN
            rd_word_w = (k == 0) ? coef_i[31:0] : shadow_q[32*k +: 32];
`else
            rd_word_w = coef_i[32*k +: 32];
`endif
          end
        end
      end
    end
  end

  // Read FSM: captures data at accept, presents it with a one-cycle ack.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_o_q <= 1'b0;
    end else begin
      ack_q   <= 1'b0;
      err_o_q <= 1'b0;
      case (state_q)
        S_IDLE, S_ACK: begin
          if (accept_w) begin
            data_q <= rd_word_w;
            err_q  <= addr_err_w;
            if (READ_LAT == 1) begin
              state_q <= S_ACK;
              ack_q   <= 1'b1;
              rdata_q <= rd_word_w;
              err_o_q <= addr_err_w;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= WAIT_INIT;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt_q == 2'd0) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
            rdata_q <= data_q;
            err_o_q <= err_q;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Completion counter (wrapping) and dropped-read counter (saturating).
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      done_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (core_done_i) begin
        done_cnt_q <= done_cnt_q + 16'd1;
      end
      if (sys_bus_io.sys_ren && (state_q == S_WAIT) && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  assign sys_bus_io.sys_rdata = rdata_q;
  assign sys_bus_io.sys_ack   = ack_q;
  assign sys_bus_io.sys_err   = err_o_q;

endmodule

// File: tb/tb_matrix_core_3x3_reg_reader.sv
// Directed bench for matrix_core_3x3_reg_reader at READ_LAT=2, BASE_ADDR=0.
module tb_matrix_core_3x3_reg_reader;

  logic         sys_clk;
  logic         sys_rstn;
  logic [287:0] coef;
  logic         core_busy;
  logic         core_done;
  int           passed;
  int           total;

  matrix_core_3x3_reg_reader_if bus ();

  matrix_core_3x3_reg_reader #(
    .BASE_ADDR(20'h00000),
    .READ_LAT (2),
    .ID_WORD  (32'h4D4D3333)
  ) dut (
    .sys_clk_i  (sys_clk),
    .sys_rstn_i (sys_rstn),
    .sys_bus_io (bus.slave),
    .coef_i     (coef),
    .core_busy_i(core_busy),
    .core_done_i(core_done)
  );

`ifdef MM3X3_RD_SNAPSHOT_EN
  localparam logic SB = 1'b1;
  localparam logic [31:0] C8_EXP = 32'hC0DE0008;
`else
  localparam logic SB = 1'b0;
  localparam logic [31:0] C8_EXP = 32'hDEADBEEF;
`endif

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Read issued in the current cycle; checks ack timing, data and err.
  task automatic do_read(input string tag, input logic [19:0] a,
                         input logic [31:0] exp_data, input logic exp_err);
    bus.sys_addr = a;
    bus.sys_ren  = 1'b1;
    step();
    bus.sys_ren = 1'b0;
    core_done   = 1'b0;
    check({tag, "_ack_early"}, {31'b0, bus.sys_ack}, 32'd0);
    step();
    check({tag, "_ack"},   {31'b0, bus.sys_ack}, 32'd1);
    check({tag, "_rdata"}, bus.sys_rdata, exp_data);
    check({tag, "_err"},   {31'b0, bus.sys_err}, {31'b0, exp_err});
    step();
    check({tag, "_ack_drop"}, {31'b0, bus.sys_ack}, 32'd0);
    check({tag, "_hold"},     bus.sys_rdata, exp_data);
  endtask

  initial begin
    passed        = 0;
    total         = 0;
    sys_rstn      = 1'b0;
    bus.sys_addr  = '0;
    bus.sys_ren   = 1'b0;
    core_busy     = 1'b0;
    core_done     = 1'b0;
    for (int k = 0; k < 9; k++) coef[32*k +: 32] = 32'hC0DE0000 + 32'(k);
    coef[32*4 +: 32] = 32'h12345678;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rstn = 1'b1;
    check("rst_rdata", bus.sys_rdata, 32'd0);
    check("rst_ack",   {31'b0, bus.sys_ack}, 32'd0);
    check("rst_err",   {31'b0, bus.sys_err}, 32'd0);
    step();

    do_read("id", 20'h00028, 32'h4D4D3333, 1'b0);
    do_read("c0_a", 20'h00000, 32'hC0DE0000, 1'b0);

    // c4 changes right after accept; captured value must be returned.
    bus.sys_addr = 20'h00010;
    bus.sys_ren  = 1'b1;
    step();
    bus.sys_ren = 1'b0;
    coef[32*4 +: 32] = 32'h0;
    check("c4_ack_early", {31'b0, bus.sys_ack}, 32'd0);
    step();
    check("c4_ack",   {31'b0, bus.sys_ack}, 32'd1);
    check("c4_rdata", bus.sys_rdata, 32'h12345678);
    step();

    do_read("off2c", 20'h0002C, 32'd0, 1'b1);
    do_read("off05", 20'h00005, 32'd0, 1'b1);
    do_read("c0_b",  20'h00000, 32'hC0DE0000, 1'b0);

    // Request during WAIT is dropped.
    bus.sys_addr = 20'h00008;
    bus.sys_ren  = 1'b1;
    step();
    bus.sys_addr = 20'h00028;
    check("drop_ack_early", {31'b0, bus.sys_ack}, 32'd0);
    step();
    bus.sys_ren = 1'b0;
    check("drop_ack",   {31'b0, bus.sys_ack}, 32'd1);
    check("drop_rdata", bus.sys_rdata, 32'hC0DE0002);
    step();
    check("drop_noack1", {31'b0, bus.sys_ack}, 32'd0);
    step();
    check("drop_noack2", {31'b0, bus.sys_ack}, 32'd0);
    do_read("stat_drop", 20'h00024, {8'd1, 16'd0, 5'b0, SB, 1'b0, 1'b1}, 1'b0);

    // Three done pulses, then status with busy; then a done coincident with sample.
    repeat (3) begin
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      step();
    end
    core_busy = 1'b1;
    do_read("stat_done3", 20'h00024, {8'd1, 16'd3, 5'b0, SB, 1'b1, 1'b1}, 1'b0);
    core_busy = 1'b0;
    core_done = 1'b1;
    do_read("stat_coinc", 20'h00024, {8'd1, 16'd3, 5'b0, SB, 1'b0, 1'b1}, 1'b0);
    do_read("stat_done4", 20'h00024, {8'd1, 16'd4, 5'b0, SB, 1'b0, 1'b1}, 1'b0);

    // Back-to-back: new request in the ACK cycle.
    bus.sys_addr = 20'h00028;
    bus.sys_ren  = 1'b1;
    step();
    bus.sys_ren = 1'b0;
    step();
    check("b2b_ack1", bus.sys_rdata, 32'h4D4D3333);
    bus.sys_addr = 20'h00004;
    bus.sys_ren  = 1'b1;
    step();
    bus.sys_ren = 1'b0;
    check("b2b_gap", {31'b0, bus.sys_ack}, 32'd0);
    step();
    check("b2b_ack2",   {31'b0, bus.sys_ack}, 32'd1);
    check("b2b_rdata2", bus.sys_rdata, 32'hC0DE0001);
    step();

    // Snapshot behaviour on c8.
    do_read("snap_c0", 20'h00000, 32'hC0DE0000, 1'b0);
    coef[32*8 +: 32] = 32'hDEADBEEF;
    do_read("snap_c8", 20'h00020, C8_EXP, 1'b0);

    // Reset during WAIT abandons the read.
    bus.sys_addr = 20'h00028;
    bus.sys_ren  = 1'b1;
    step();
    bus.sys_ren = 1'b0;
    sys_rstn    = 1'b0;
    #1;
    check("midrst_rdata", bus.sys_rdata, 32'd0);
    step();
    sys_rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("midrst_noack", {31'b0, bus.sys_ack}, 32'd0);
      step();
    end
    do_read("stat_rst", 20'h00024, 32'h00000001, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
